// File: rtl/id_branch_pkg.sv
// id_branch_pkg: shared constants, state enum and branch-condition helpers
// for the ID-stage branch resolution unit.
package id_branch_pkg;

  // Control-flow opcodes
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Branch condition selects (funct3)
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Bit positions inside the comparator result
  localparam int COM_EQ  = 0;
  localparam int COM_LT  = 1;
  localparam int COM_LTU = 2;

  typedef enum logic {S_IDLE, S_STALL} state_e;

  // True for the six defined branch conditions; 010/011 are dead encodings
  function automatic logic f3_is_cond(input logic [2:0] f3);
    return (f3 != 3'b010) && (f3 != 3'b011);
  endfunction

  // Maps a funct3 select and comparator result to a taken decision
  function automatic logic branch_taken(input logic [2:0] f3, input logic [2:0] com);
    logic tk;
    tk = 1'b0;
    case (f3)
      F3_BEQ:  tk = com[COM_EQ];
      F3_BNE:  tk = !com[COM_EQ];
      F3_BLT:  tk = com[COM_LT];
      F3_BGE:  tk = !com[COM_LT];
      F3_BLTU: tk = com[COM_LTU];
      F3_BGEU: tk = !com[COM_LTU];
      default: tk = 1'b0;
    endcase
    return tk;
  endfunction

endpackage

// File: rtl/id_branch_resolve_if.sv
// id_branch_resolve_if: ID-stage instruction, comparator and producer
// signals going into the resolver, and the redirect/stall signals coming out.
interface id_branch_resolve_if #(parameter int XLEN = 32) ();

  logic            stall_in;
  logic            id_valid;
  logic [6:0]      id_opcode;
  logic [2:0]      id_funct3;
  logic [XLEN-1:0] id_pc;
  logic [XLEN-1:0] id_imm;
  logic [XLEN-1:0] id_rs1_data;
  logic [4:0]      id_rs1_addr;
  logic [4:0]      id_rs2_addr;
  logic [2:0]      com_out;
  logic [4:0]      ex_rd_addr;
  logic [4:0]      mem_rd_addr;
  logic            ex_reg_write;
  logic            ex_mem_read;
  logic            mem_mem_read;

  logic            pc_redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            if_flush;
  logic            id_stall;

  // Pipeline side: presents the ID instruction, observes redirect/stall
  modport master (
    output stall_in, id_valid, id_opcode, id_funct3, id_pc, id_imm, id_rs1_data,
           id_rs1_addr, id_rs2_addr, com_out, ex_rd_addr, mem_rd_addr,
           ex_reg_write, ex_mem_read, mem_mem_read,
    input  pc_redirect, redirect_pc, if_flush, id_stall
  );

  // Resolver side
  modport slave (
    input  stall_in, id_valid, id_opcode, id_funct3, id_pc, id_imm, id_rs1_data,
           id_rs1_addr, id_rs2_addr, com_out, ex_rd_addr, mem_rd_addr,
           ex_reg_write, ex_mem_read, mem_mem_read,
    output pc_redirect, redirect_pc, if_flush, id_stall
  );

endinterface

// File: rtl/id_branch_hazard.sv
// id_branch_hazard: number of ID stall cycles needed before the comparator
// sees valid branch operands. A load in EX costs LOAD_STALL cycles; an ALU
// result in EX or a load in MEM costs one. The largest requirement wins.
module id_branch_hazard #(
  parameter int LOAD_STALL = 2,
  parameter int NW         = 2
) (
  input  logic [4:0]    rs1_addr,
  input  logic [4:0]    rs2_addr,
  input  logic          use_rs1,
  input  logic          use_rs2,
  input  logic [4:0]    ex_rd_addr,
  input  logic [4:0]    mem_rd_addr,
  input  logic          ex_reg_write,
  input  logic          ex_mem_read,
  input  logic          mem_mem_read,
  output logic [NW-1:0] need
);

  logic live1, live2;
  logic ex_load_hit, one_cycle_hit;
  logic [NW-1:0] n_load, n_one;

  // Match each used, non-x0 source against the producers and take the maximum
  always_comb begin
    live1 = use_rs1 && (rs1_addr != 5'd0);
    live2 = use_rs2 && (rs2_addr != 5'd0);

    ex_load_hit = ex_mem_read &&
                  ((live1 && rs1_addr == ex_rd_addr) || (live2 && rs2_addr == ex_rd_addr));

    one_cycle_hit = (ex_reg_write &&
                     ((live1 && rs1_addr == ex_rd_addr) || (live2 && rs2_addr == ex_rd_addr))) ||
                    (mem_mem_read &&
                     ((live1 && rs1_addr == mem_rd_addr) || (live2 && rs2_addr == mem_rd_addr)));

    n_load = ex_load_hit ? NW'(LOAD_STALL) : '0;
    n_one  = one_cycle_hit ? NW'(1) : '0;
    need   = (n_load > n_one) ? n_load : n_one;
  end

endmodule

// File: rtl/id_branch_resolve.sv
// id_branch_resolve: ID-stage branch/jump resolution. Decides taken/not-taken
// from the comparator result, computes the target, drives PC redirect and
// IF flush, and holds ID until branch operands are valid.
// Optional build macro BRANCH_PERF_CNT_EN adds three 32-bit wrapping
// performance counters (resolutions, taken resolutions, stall cycles).
module id_branch_resolve
  import id_branch_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int LOAD_STALL = 2
) (
  input  logic        clk,
  input  logic        rst,
  id_branch_resolve_if.slave bus
`ifdef BRANCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_branch_cnt,
  output logic [31:0] perf_taken_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int NW = $clog2(LOAD_STALL + 2);

  logic            is_branch, is_jal, is_jalr;
  logic            ctrl, use_rs1, use_rs2, taken;
  logic [XLEN-1:0] target;
  logic [NW-1:0]   need;

  state_e          state_q, state_d;
  logic [NW-1:0]   cnt_q, cnt_d;
  logic            resolve, stall_raw;

  // Decode the control instruction, its condition and its target
  always_comb begin
    is_branch = (bus.id_opcode == OPC_BRANCH);
    is_jal    = (bus.id_opcode == OPC_JAL);
    is_jalr   = (bus.id_opcode == OPC_JALR);
    ctrl      = bus.id_valid && (is_branch || is_jal || is_jalr);
    use_rs1   = ctrl && ((is_branch && f3_is_cond(bus.id_funct3)) || is_jalr);
    use_rs2   = ctrl && is_branch && f3_is_cond(bus.id_funct3);
    taken     = is_jal || is_jalr || (is_branch && branch_taken(bus.id_funct3, bus.com_out));
    if (is_jalr) begin
      target = (bus.id_rs1_data + bus.id_imm) & ~XLEN'(1);
    end else begin
      target = bus.id_pc + bus.id_imm;
    end
  end

  id_branch_hazard #(
    .LOAD_STALL (LOAD_STALL),
    .NW         (NW)
  ) u_hazard (
    .rs1_addr     (bus.id_rs1_addr),
    .rs2_addr     (bus.id_rs2_addr),
    .use_rs1      (use_rs1),
    .use_rs2      (use_rs2),
    .ex_rd_addr   (bus.ex_rd_addr),
    .mem_rd_addr  (bus.mem_rd_addr),
    .ex_reg_write (bus.ex_reg_write),
    .ex_mem_read  (bus.ex_mem_read),
    .mem_mem_read (bus.mem_mem_read),
    .need         (need)
  );

  // Stall FSM: enter S_STALL on a hazard, count down, resolve at zero; stall_in freezes it
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    resolve   = 1'b0;
    stall_raw = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl) begin
          if (need != '0) begin
            stall_raw = 1'b1;
            if (!bus.stall_in) begin
              state_d = S_STALL;
              cnt_d   = need - NW'(1);
            end
          end else begin
            resolve = 1'b1;
          end
        end
      end
      S_STALL: begin
        stall_raw = (cnt_q != '0);
        resolve   = ctrl && (cnt_q == '0);
        if (!bus.stall_in) begin
          if (cnt_q == '0) begin
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q - NW'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and countdown registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Redirect/flush/stall outputs, forced quiet while reset is asserted
  always_comb begin
    bus.pc_redirect = !rst && resolve && taken;
    bus.redirect_pc = bus.pc_redirect ? target : '0;
    bus.if_flush    = bus.pc_redirect && !bus.stall_in;
    bus.id_stall    = !rst && stall_raw;
  end

`ifdef BRANCH_PERF_CNT_EN
  logic [31:0] perf_branch_cnt_q, perf_branch_cnt_d;
  logic [31:0] perf_taken_cnt_q,  perf_taken_cnt_d;
  logic [31:0] perf_stall_cnt_q,  perf_stall_cnt_d;

  // Advance the event counters only on cycles the pipeline is not frozen
  always_comb begin
    perf_branch_cnt_d = perf_branch_cnt_q;
    perf_taken_cnt_d  = perf_taken_cnt_q;
    perf_stall_cnt_d  = perf_stall_cnt_q;
    if (!bus.stall_in) begin
      if (resolve)          perf_branch_cnt_d = perf_branch_cnt_q + 32'd1;
      if (resolve && taken) perf_taken_cnt_d  = perf_taken_cnt_q + 32'd1;
      if (stall_raw)        perf_stall_cnt_d  = perf_stall_cnt_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_branch_cnt_q <= '0;
      perf_taken_cnt_q  <= '0;
      perf_stall_cnt_q  <= '0;
    end else begin
      perf_branch_cnt_q <= perf_branch_cnt_d;
      perf_taken_cnt_q  <= perf_taken_cnt_d;
      perf_stall_cnt_q  <= perf_stall_cnt_d;
    end
  end

  assign perf_branch_cnt = perf_branch_cnt_q;
  assign perf_taken_cnt  = perf_taken_cnt_q;
  assign perf_stall_cnt  = perf_stall_cnt_q;
`endif

endmodule

// File: doc/id_branch_resolve.md
# id_branch_resolve

Branch/jump resolution unit in the ID stage, directly downstream of the ID-stage comparator. It consumes the comparator's 3-bit result and the decoded control-flow instruction. It decides taken/not-taken, computes the target, and drives the PC redirect and IF flush. It also runs the hazard-stall FSM that holds ID until branch operands are valid at the comparator.

## Interface
Parameters:
- XLEN, 32, datapath/PC width
- LOAD_STALL, 2, ID stall cycles when a load in EX writes a branch source

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- stall_in  in  1  global pipeline freeze (cache miss); freezes FSM and counters
- id_valid  in  1  ID holds a valid instruction
- id_opcode  in  7  decoded opcode
- id_funct3  in  3  branch condition select
- id_pc  in  XLEN  PC of ID instruction
- id_imm  in  XLEN  sign-extended B/J/I immediate
- id_rs1_data  in  XLEN  forwarded rs1 value (JALR base)
- id_rs1_addr, id_rs2_addr  in  5 each  source registers
- com_out  in  3  comparator result: [0] equal, [1] signed less-than, [2] unsigned less-than
- ex_rd_addr, mem_rd_addr  in  5 each  destination registers in EX and MEM
- ex_reg_write, ex_mem_read, mem_mem_read  in  1 each  producer flags
- pc_redirect  out  1  fetch must load redirect_pc
- redirect_pc  out  XLEN  branch/jump target
- if_flush  out  1  squash instruction currently in IF
- id_stall  out  1  hold PC and IF/ID register

## Operation
- Control instructions: BRANCH 1100011, JAL 1101111, JALR 1100111. Other opcodes never stall or redirect.
- Branch condition by funct3:
  - 000 BEQ = com_out[0]; 001 BNE = !com_out[0]
  - 100 BLT = com_out[1]; 101 BGE = !com_out[1]
  - 110 BLTU = com_out[2]; 111 BGEU = !com_out[2]
  - 010/011 are not taken, with no stall.
- Targets:
  - Branch and JAL: id_pc + id_imm.
  - JALR: (id_rs1_data + id_imm) & ~1.
  - All sums are modulo 2^XLEN; wrap-around is silently allowed.
- Hazard need N, evaluated on the sources actually used: rs1+rs2 for branches, rs1 for JALR, none for JAL. Register x0 never hazards.
  - N = LOAD_STALL if a source equals ex_rd_addr with ex_mem_read.
  - Otherwise N = 1 if a source equals ex_rd_addr with ex_reg_write, or equals mem_rd_addr with mem_mem_read.
  - Otherwise N = 0. The maximum rule wins.
- FSM states: S_IDLE and S_STALL, plus a down-counter cnt.
  - In S_IDLE with a control instruction, id_valid high and N>0: id_stall=1, go to S_STALL, cnt=N-1.
  - In S_IDLE with N=0: resolve this cycle.
  - In S_STALL: id_stall=(cnt!=0). cnt decrements each cycle. When cnt==0, resolve this cycle and return to S_IDLE.
- Resolve: pc_redirect = taken (jumps are always taken). redirect_pc = target; it is 0 when pc_redirect is 0.
- if_flush = pc_redirect & !stall_in.
- With stall_in high: state, cnt and counters hold. No new S_IDLE→S_STALL entry. A resolving redirect stays asserted until the first cycle with stall_in low.

## Timing
- Reset values: state S_IDLE, cnt 0, all outputs 0, perf counters 0.
- pc_redirect, redirect_pc, if_flush and id_stall are combinational from inputs and state. There are no registered outputs.
- Resolution cycle count (with stall_in low):
  - N=0: resolves in the ID cycle.
  - N=1: 1 stall cycle, resolves in the 2nd cycle.
  - N=2: 2 stall cycles, resolves in the 3rd cycle.
- Reset asserted mid-stall: S_IDLE and cnt=0 on the next edge. id_stall drops immediately after that edge.
- Simultaneous stall_in and resolve: redirect is held, if_flush=0.

## Configuration
- BRANCH_PERF_CNT_EN defined:
  - Adds output ports perf_branch_cnt, perf_taken_cnt and perf_stall_cnt, each 32 bits, wrapping.
  - perf_branch_cnt counts each resolution of any control instruction.
  - perf_taken_cnt counts each resolution with pc_redirect high.
  - perf_stall_cnt counts each cycle with id_stall high and stall_in low.
  - All counters are frozen by stall_in.
- BRANCH_PERF_CNT_EN undefined: the ports and registers do not exist.

## Structure
- Package id_branch_pkg holds:
  - opcode constants
  - funct3 constants
  - the state enum {S_IDLE, S_STALL}
  - the com_out bit-index constants
- Sub-module id_branch_hazard: combinational computation of N from the register addresses and producer flags.

## Test plan
- BEQ, com_out=001, pc=0x100, imm=0x20, no hazard → same cycle: pc_redirect=1, redirect_pc=0x120, if_flush=1.
- BLTU with rs1 = EX load rd (ex_mem_read=1) → id_stall=1 for 2 cycles, then 3rd cycle resolves per com_out[2].
- JALR, rs1_data=0x1003, imm=0x4 → redirect_pc=0x1006, no stall when there is no hazard.
- Taken BNE while stall_in=1 for 3 cycles → pc_redirect held 3 cycles with if_flush=0, then if_flush=1 in the first cycle after stall_in falls.
- rst=1 during the second cycle of a load stall → next cycle id_stall=0 and all outputs 0.
- funct3=010 branch, and hazard on x0 → no redirect, no stall.
